// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate vector sequencer: FSM state encoding and
// reference-function select codes.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } gvs_state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference: the expected gate output for a given vector under
// the selected reduction function.
module gate_ref_model
  import gate_test_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [1:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_NAND: expected = ~&vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus/check sequencer for a small combinational gate.
// Optional macro GVS_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op_sel,
  output logic [N_IN-1:0] vec_out,
  output logic            vec_valid,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;
  localparam logic [N_IN:0]    ERR_MAX  = {1'b1, {N_IN{1'b0}}};

  gvs_state_t      state_q, state_n;
  logic [N_IN-1:0] vec_q, vec_n;
  logic            valid_q, valid_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            pass_q, pass_n;
  logic [N_IN:0]   err_q, err_n;
  logic [N_IN-1:0] ff_q, ff_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]      op_q, op_n;

  logic expected;
  logic mismatch;
  logic finish;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .op       (op_q),
    .vec      (vec_q),
    .expected (expected)
  );

  assign mismatch = (dut_y != expected);

  // Next-state and next-result logic; every register holds unless a state acts on it.
  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    valid_n = valid_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;
    err_n   = err_q;
    ff_n    = ff_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    finish  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_APPLY;
          vec_n   = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          ff_n    = '0;
          cnt_n   = '0;
          op_n    = op_sel;
        end
      end

      ST_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_n = ST_SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_n = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
          if (err_q == '0) begin
            ff_n = vec_q;
          end
        end
`ifdef GVS_STOP_ON_FAIL_EN
        finish = (vec_q == VEC_LAST) || mismatch;
`else
        finish = (vec_q == VEC_LAST);
`endif
        cnt_n = '0;
        if (finish) begin
          state_n = ST_DONE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n = ST_APPLY;
          vec_n   = vec_q + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Single register bank; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_AND;
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      ff_q    <= ff_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
    end
  end

  assign vec_out    = vec_q;
  assign vec_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomised self-checking bench for gate_vector_sequencer; the gate under
// test is emulated as a truth table indexed by vec_out.
module tb_gate_vector_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 2;
  localparam int NV   = 1 << N;
  localparam int PER  = HOLD + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op_sel;
  logic [N-1:0]  vec_out;
  logic          vec_valid;
  logic          dut_y;
  logic          busy;
  logic          done;
  logic          pass;
  logic [N:0]    err_count;
  logic [N-1:0]  first_fail;
  logic [NV-1:0] gate_tbl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dut_y = gate_tbl[vec_out];

  gate_vector_sequencer #(.N_IN(N), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_sel     (op_sel),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .dut_y      (dut_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  // Expected gate output from the function's definition, via popcount.
  function automatic bit ref_bit(input logic [1:0] op, input int v);
    int ones;
    ones = $countones(v);
    case (op)
      2'd0:    return (ones == N);
      2'd1:    return (ones != 0);
      2'd2:    return (ones % 2 == 1);
      default: return (ones != N);
    endcase
  endfunction

  function automatic logic [NV-1:0] exact_tbl(input logic [1:0] op);
    logic [NV-1:0] t;
    for (int v = 0; v < NV; v++) t[v] = ref_bit(op, v);
    return t;
  endfunction

  task automatic do_sweep(input logic [1:0] op, input logic [NV-1:0] tbl,
                          input bit poke, input string tag);
    int errs, ff, len, last;
    logic [N+2:0] obs, exp;
    errs = 0;
    ff   = 0;
    for (int v = 0; v < NV; v++) begin
      if (tbl[v] != ref_bit(op, v)) begin
        if (errs == 0) ff = v;
        errs++;
      end
    end
    len  = PER * NV;
    last = NV - 1;
`ifdef GVS_STOP_ON_FAIL_EN
    if (errs > 0) begin
      errs = 1;
      len  = PER * (ff + 1);
      last = ff;
    end
`endif
    gate_tbl = tbl;
    @(negedge clk);
    op_sel = op;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp = {N'(i / PER), 1'b1, 1'b1, 1'b0};
      obs = {vec_out, vec_valid, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL %s cycle %0d {vec,valid,busy,done}: got %b expected %b", tag, i, obs, exp);
      end
      if (poke && (i == 3 || i == 7) && (i + 2 < len)) begin
        start  = 1'b1;
        op_sel = ~op;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp = {N'(last), 1'b0, 1'b0, 1'b1};
    obs = {vec_out, vec_valid, busy, done};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s end {vec,valid,busy,done}: got %b expected %b", tag, obs, exp);
    end
    n_checks++;
    if (pass !== (errs == 0)) begin
      n_fail++;
      $display("[TB] FAIL %s pass: got %b expected %b", tag, pass, (errs == 0));
    end
    n_checks++;
    if (err_count !== (N + 1)'(errs)) begin
      n_fail++;
      $display("[TB] FAIL %s err_count: got %0d expected %0d", tag, err_count, errs);
    end
    n_checks++;
    if (first_fail !== N'(ff)) begin
      n_fail++;
      $display("[TB] FAIL %s first_fail: got %0d expected %0d", tag, first_fail, ff);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [3*N+5:0] obs;
    obs = {vec_out, vec_valid, busy, done, pass, err_count, first_fail};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL %s outputs: got %b expected all zero", tag, obs);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    op_sel   = 2'd0;
    gate_tbl = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("idle_hold");
  endtask

  task automatic test_matching_gates();
    for (int op = 0; op < 4; op++) do_sweep(2'(op), exact_tbl(2'(op)), 1'b0, "match");
  endtask

  task automatic test_faulty_gates();
    do_sweep(2'd0, '1, 1'b0, "const1_vs_and");
    do_sweep(2'd0, exact_tbl(2'd1), 1'b0, "or_vs_and");
    do_sweep(2'd2, exact_tbl(2'd3), 1'b0, "nand_vs_xor");
  endtask

  task automatic test_random();
    logic [1:0]    op;
    logic [NV-1:0] tbl;
    for (int k = 0; k < 8; k++) begin
      op  = 2'($urandom_range(0, 3));
      tbl = (k % 3 == 0) ? exact_tbl(op) : NV'($urandom);
      do_sweep(op, tbl, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_sweep();
    gate_tbl = '1;
    @(negedge clk);
    op_sel = 2'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_sweep_reset");
    rst = 1'b0;
    do_sweep(2'd0, exact_tbl(2'd0), 1'b0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    do_sweep(2'd1, exact_tbl(2'd1), 1'b1, "busy_start");
    do_sweep(2'd0, exact_tbl(2'd1), 1'b1, "busy_start_fail");
  endtask

  task automatic test_back_to_back();
    do_sweep(2'd3, '0, 1'b0, "b2b_fail");
    do_sweep(2'd3, exact_tbl(2'd3), 1'b0, "b2b_clean");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_matching_gates();
    test_faulty_gates();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
